mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Stage directly downstream of execute: EX/MEM pipeline register, word-addressed data memory, branch
//  resolution (pcsrc = Branch & zero) and MEM/WB pipeline register. Consumes execute's ctlwb/ctlm/branch
//  target/zero/ALU result/store data/dest reg; feeds fetch (pcsrc, target), forwarding unit and write-back.
// PARAMETERS
//  DMEM_WORDS  256  data memory depth in 32-bit words (power of 2); ADDR_W = $clog2(DMEM_WORDS) derived
// PORTS
//  clk             in   1   clock, all state updates on rising edge
//  reset           in   1   synchronous, active-high
//  stall           in   1   freeze EX/MEM and MEM/WB (hazard unit)
//  flush           in   1   load bubble into EX/MEM (squash instruction leaving execute)
//  ctlwb_in        in   2   {RegWrite, MemtoReg} from execute
//  ctlm_in         in   3   {Branch, MemRead, MemWrite} from execute
//  target_in       in   32  branch target from execute adder
//  zero_in         in   1   ALU zero flag
//  alu_in          in   32  ALU result / memory byte address
//  wdata_in        in   32  store data (rdata2 passthrough)
//  dest_in         in   5   destination register
//  pcsrc           out  1   branch taken, to fetch PC mux
//  branch_target   out  32  EX/MEM registered target
//  exmem_regwrite  out  1   EX/MEM RegWrite (forwarding)
//  exmem_dest      out  5   EX/MEM dest (forwarding)
//  exmem_alu       out  32  EX/MEM ALU result (forwarding)
//  ctlwb_out       out  2   MEM/WB {RegWrite, MemtoReg}
//  rdata_out       out  32  MEM/WB loaded word
//  alu_out         out  32  MEM/WB ALU result
//  dest_out        out  5   MEM/WB dest register
// BEHAVIOUR
//  - Reset (sync, reset=1 at edge): all EX/MEM and MEM/WB fields <= 0; every output reads 0 next cycle.
//    Memory write gated off while reset=1; memory contents NOT cleared (zero at time 0 only).
//  - Normal edge (stall=0, flush=0): EX/MEM <= inputs; MEM/WB <= {EX/MEM ctlwb, dmem read, EX/MEM alu, dest}.
//  - Latency: inputs at edge N appear on exmem_*/pcsrc/branch_target after N; on MEM/WB outputs after N+1.
//  - pcsrc = exmem Branch & exmem zero, combinational from EX/MEM only (never from *_in).
//  - Memory: word index = exmem_alu[ADDR_W+1:2]; bits [1:0] ignored; upper bits ignored (address wraps).
//    Read combinational from array; write on edge when exmem MemWrite & !stall & !reset.
//    MemRead=0: rdata_out loads 0. MemRead & MemWrite both set: write happens, read returns old word.
//    Store at edge K visible to a load in EX/MEM during cycle after K (write-then-read, no bypass needed).
//  - flush=1 (stall=0): EX/MEM ctlwb/ctlm/zero <= 0 (bubble), data fields don't-care; MEM/WB advances.
//  - stall=1: both registers hold; no memory write; pcsrc/target held stable. stall beats flush
//    (flush ignored; hazard unit re-asserts it after stall drops). A held store writes exactly once.
//  - No FSM beyond the two pipeline registers; no X may reach any output after first reset edge.
// STRUCTURE
//  - Shared package/header: CTLWB_REGWRITE=1, CTLWB_MEMTOREG=0, CTLM_BRANCH=2, CTLM_MEMREAD=1,
//    CTLM_MEMWRITE=0 bit positions; bubble constants CTLWB_NOP=2'b00, CTLM_NOP=3'b000.
//  - One sub-module: data_memory (clk, we, addr[ADDR_W-1:0], wdata, rdata; async read, sync write).
//  - Pipeline registers and pcsrc logic inline in mem_stage.
// TESTING
//  1 Store/load: sw alu_in=0x10 wdata_in=0xDEADBEEF ctlm=001; next cycle lw alu_in=0x10 ctlm=010
//    ctlwb=11 dest=5 -> two edges after lw: rdata_out=0xDEADBEEF, ctlwb_out=11, dest_out=5.
//  2 Branch: ctlm=100 zero_in=1 target_in=0x40 -> after one edge pcsrc=1, branch_target=0x40;
//    same with zero_in=0 -> pcsrc=0.
//  3 Flush: sw alu_in=0x20 wdata_in=0x1234 with flush=1 -> no write (later lw 0x20 returns prior 0),
//    exmem_regwrite=0, pcsrc=0.
//  4 Stall: lw in EX/MEM, stall=1 for 3 cycles -> all outputs constant; sw stalled 3 cycles writes once;
//    flush during stall ignored.
//  5 Reset mid-op: reset=1 with sw pending in EX/MEM -> no write, all outputs 0 next cycle,
//    previously stored word at 0x10 still 0xDEADBEEF after reset.
//  6 Wrap: DMEM_WORDS=256, sw alu_in=0x403 wdata_in=0xA5A5A5A5 -> lw alu_in=0x000 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared control-field bit positions, bubble constants and pipeline-register
// layouts for the memory stage.
package mem_stage_pkg;

  localparam int CTLWB_REGWRITE = 1;
  localparam int CTLWB_MEMTOREG = 0;

  localparam int CTLM_BRANCH   = 2;
  localparam int CTLM_MEMREAD  = 1;
  localparam int CTLM_MEMWRITE = 0;

  localparam logic [1:0] CTLWB_NOP = 2'b00;
  localparam logic [2:0] CTLM_NOP  = 3'b000;

  typedef struct packed {
    logic [1:0]  ctlwb;
    logic [2:0]  ctlm;
    logic [31:0] target;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  dest;
  } exmem_t;

  typedef struct packed {
    logic [1:0]  ctlwb;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  dest;
  } memwb_t;

  // Non-load instructions carry a zero word into write-back.
  function automatic logic [31:0] load_word(input logic mem_read, input logic [31:0] word);
    return mem_read ? word : 32'h0;
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: asynchronous read, write on the rising edge.
module data_memory #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  // Contents start at zero and are never cleared by reset.
  logic [31:0] ram_q [DEPTH] = '{default: 32'h0};

  always_ff @(posedge clk) begin
    if (we) begin
      ram_q[addr] <= wdata;
    end
  end

  assign rdata = ram_q[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data memory access, branch resolution
// and MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_WORDS = 256,
  localparam int ADDR_W    = $clog2(DMEM_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  ctlwb_in,
  input  logic [2:0]  ctlm_in,
  input  logic [31:0] target_in,
  input  logic        zero_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] wdata_in,
  input  logic [4:0]  dest_in,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        exmem_regwrite,
  output logic [4:0]  exmem_dest,
  output logic [31:0] exmem_alu,
  output logic [1:0]  ctlwb_out,
  output logic [31:0] rdata_out,
  output logic [31:0] alu_out,
  output logic [4:0]  dest_out
);

  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  // Byte offset and bits above the memory depth are dropped, so addresses wrap.
  assign mem_addr = exmem_q.alu[ADDR_W+1:2];
  assign mem_we   = exmem_q.ctlm[CTLM_MEMWRITE] & ~stall & ~reset;

  data_memory #(
    .DEPTH  (DMEM_WORDS),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (exmem_q.wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    exmem_d = exmem_q;
    if (!stall) begin
      exmem_d.ctlwb  = ctlwb_in;
      exmem_d.ctlm   = ctlm_in;
      exmem_d.target = target_in;
      exmem_d.zero   = zero_in;
      exmem_d.alu    = alu_in;
      exmem_d.wdata  = wdata_in;
      exmem_d.dest   = dest_in;
      // A squashed instruction keeps its data fields but loses every side effect.
      if (flush) begin
        exmem_d.ctlwb = CTLWB_NOP;
        exmem_d.ctlm  = CTLM_NOP;
        exmem_d.zero  = 1'b0;
      end
    end
  end

  always_comb begin
    memwb_d = memwb_q;
    if (!stall) begin
      memwb_d.ctlwb = exmem_q.ctlwb;
      memwb_d.rdata = load_word(exmem_q.ctlm[CTLM_MEMREAD], mem_rdata);
      memwb_d.alu   = exmem_q.alu;
      memwb_d.dest  = exmem_q.dest;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign pcsrc          = exmem_q.ctlm[CTLM_BRANCH] & exmem_q.zero;
  assign branch_target  = exmem_q.target;
  assign exmem_regwrite = exmem_q.ctlwb[CTLWB_REGWRITE];
  assign exmem_dest     = exmem_q.dest;
  assign exmem_alu      = exmem_q.alu;

  assign ctlwb_out = memwb_q.ctlwb;
  assign rdata_out = memwb_q.rdata;
  assign alu_out   = memwb_q.alu;
  assign dest_out  = memwb_q.dest;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed scenarios followed by random traffic,
// checked against an instruction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, zero_in;
  logic [1:0]  ctlwb_in;
  logic [2:0]  ctlm_in;
  logic [31:0] target_in, alu_in, wdata_in;
  logic [4:0]  dest_in;
  logic        pcsrc, exmem_regwrite;
  logic [31:0] branch_target, exmem_alu, rdata_out, alu_out;
  logic [4:0]  exmem_dest, dest_out;
  logic [1:0]  ctlwb_out;

  always #5 clk = ~clk;

  mem_stage #(.DMEM_WORDS(256)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .target_in(target_in), .zero_in(zero_in),
    .alu_in(alu_in), .wdata_in(wdata_in), .dest_in(dest_in),
    .pcsrc(pcsrc), .branch_target(branch_target), .exmem_regwrite(exmem_regwrite),
    .exmem_dest(exmem_dest), .exmem_alu(exmem_alu), .ctlwb_out(ctlwb_out),
    .rdata_out(rdata_out), .alu_out(alu_out), .dest_out(dest_out)
  );

  typedef struct {
    bit        reset, stall, flush, zero;
    bit [1:0]  ctlwb;
    bit [2:0]  ctlm;
    bit [31:0] target, alu, wdata;
    bit [4:0]  dest;
  } stim_t;

  // One instruction as the model sees it; known=0 means its data fields are don't-care.
  typedef struct {
    bit        known, zero;
    bit [1:0]  ctlwb;
    bit [2:0]  ctlm;
    bit [31:0] target, alu, wdata, rdata;
    bit [4:0]  dest;
  } instr_t;

  typedef struct {
    bit        pcsrc, ex_regwrite, ex_known, wb_known;
    bit [31:0] target, ex_alu, rdata, wb_alu;
    bit [4:0]  ex_dest, wb_dest;
    bit [1:0]  wb_ctlwb;
  } exp_t;

  bit [31:0] ref_mem [256];
  instr_t    in_mem, in_wb;
  exp_t      exp_q[$];
  int        vectors = 0;
  int        miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Advance the model by one clock edge with the given stimulus.
  task automatic model_edge(input stim_t s);
    instr_t nxt;
    int     word;
    if (s.reset) begin
      in_mem = '{known: 1'b1, default: '0};
      in_wb  = '{known: 1'b1, default: '0};
    end else if (!s.stall) begin
      word = int'(in_mem.alu / 4) % 256;
      in_wb = in_mem;
      in_wb.rdata = in_mem.ctlm[1] ? ref_mem[word] : 32'h0;
      if (in_mem.ctlm[0]) ref_mem[word] = in_mem.wdata;
      nxt = '{known: !s.flush, zero: s.zero && !s.flush,
              ctlwb: s.flush ? 2'b00 : s.ctlwb, ctlm: s.flush ? 3'b000 : s.ctlm,
              target: s.target, alu: s.alu, wdata: s.wdata, rdata: 32'h0, dest: s.dest};
      in_mem = nxt;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.pcsrc       = in_mem.ctlm[2] && in_mem.zero;
    e.ex_regwrite = in_mem.ctlwb[1];
    e.ex_known    = in_mem.known;
    e.target      = in_mem.target;
    e.ex_alu      = in_mem.alu;
    e.ex_dest     = in_mem.dest;
    e.wb_known    = in_wb.known;
    e.wb_ctlwb    = in_wb.ctlwb;
    e.rdata       = in_wb.rdata;
    e.wb_alu      = in_wb.alu;
    e.wb_dest     = in_wb.dest;
    exp_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    reset = s.reset; stall = s.stall; flush = s.flush;
    ctlwb_in = s.ctlwb; ctlm_in = s.ctlm; target_in = s.target; zero_in = s.zero;
    alu_in = s.alu; wdata_in = s.wdata; dest_in = s.dest;
    @(posedge clk);
    model_edge(s);
    push_expected();
    #1;
  endtask

  function automatic stim_t op(input bit [2:0] ctlm, input bit [1:0] ctlwb, input bit [31:0] alu,
                               input bit [31:0] wdata, input bit [4:0] dest);
    stim_t s = '{default: '0};
    s.ctlm = ctlm; s.ctlwb = ctlwb; s.alu = alu; s.wdata = wdata; s.dest = dest;
    return s;
  endfunction

  function automatic stim_t with_ctl(input stim_t s, input bit rst, input bit stl, input bit fl);
    stim_t r = s;
    r.reset = rst; r.stall = stl; r.flush = fl;
    return r;
  endfunction

  // Monitor: every cycle the DUT presents a new pipeline state, compare it away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pcsrc", {31'h0, pcsrc}, {31'h0, e.pcsrc});
      check("exmem_regwrite", {31'h0, exmem_regwrite}, {31'h0, e.ex_regwrite});
      check("ctlwb_out", {30'h0, ctlwb_out}, {30'h0, e.wb_ctlwb});
      check("rdata_out", rdata_out, e.rdata);
      if (e.ex_known) begin
        check("branch_target", branch_target, e.target);
        check("exmem_alu", exmem_alu, e.ex_alu);
        check("exmem_dest", {27'h0, exmem_dest}, {27'h0, e.ex_dest});
      end
      if (e.wb_known) begin
        check("alu_out", alu_out, e.wb_alu);
        check("dest_out", {27'h0, dest_out}, {27'h0, e.wb_dest});
      end
    end
  end

  initial begin
    stim_t idle, s;
    idle = '{default: '0};
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    in_mem = '{default: '0};
    in_wb  = '{default: '0};

    apply(with_ctl(idle, 1, 0, 0));
    apply(with_ctl(idle, 1, 0, 0));
    apply(idle);

    // Store then load the same word.
    apply(op(3'b001, 2'b00, 32'h10, 32'hDEADBEEF, 5'd0));
    apply(op(3'b010, 2'b11, 32'h10, 32'h0, 5'd5));
    apply(idle); apply(idle);

    // Branch taken and not taken.
    s = op(3'b100, 2'b00, 32'h0, 32'h0, 5'd0); s.zero = 1; s.target = 32'h40;
    apply(s);
    s.zero = 0; s.target = 32'h80;
    apply(s);
    apply(idle);

    // Flushed store must not write.
    apply(with_ctl(op(3'b001, 2'b10, 32'h20, 32'h1234, 5'd3), 0, 0, 1));
    apply(idle);
    apply(op(3'b010, 2'b11, 32'h20, 32'h0, 5'd6));
    apply(idle); apply(idle);

    // Load held by stall, flush during stall ignored.
    apply(op(3'b010, 2'b11, 32'h10, 32'h0, 5'd7));
    apply(with_ctl(op(3'b001, 2'b10, 32'h99, 32'h77, 5'd9), 0, 1, 0));
    apply(with_ctl(op(3'b001, 2'b10, 32'h99, 32'h77, 5'd9), 0, 1, 1));
    apply(with_ctl(idle, 0, 1, 0));
    apply(idle);

    // Stalled store writes once; value then visible to a load.
    apply(op(3'b001, 2'b00, 32'h30, 32'h5555AAAA, 5'd0));
    for (int i = 0; i < 3; i++) apply(with_ctl(idle, 0, 1, 0));
    apply(idle);
    apply(op(3'b010, 2'b11, 32'h30, 32'h0, 5'd8));
    apply(idle); apply(idle);

    // Reset while a store sits in EX/MEM: no write, old word survives.
    apply(op(3'b001, 2'b00, 32'h10, 32'h11111111, 5'd0));
    apply(with_ctl(idle, 1, 0, 0));
    apply(idle);
    apply(op(3'b010, 2'b11, 32'h10, 32'h0, 5'd5));
    apply(idle); apply(idle);

    // Address wrap past the memory depth.
    apply(op(3'b001, 2'b00, 32'h403, 32'hA5A5A5A5, 5'd0));
    apply(idle);
    apply(op(3'b010, 2'b11, 32'h000, 32'h0, 5'd4));
    apply(idle); apply(idle);

    // Random traffic over a small address window so loads hit earlier stores.
    for (int n = 0; n < 400; n++) begin
      bit [2:0] ctlm_opts [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011};
      s = op(ctlm_opts[$urandom_range(0, 4)], 2'($urandom_range(0, 3)),
             {22'($urandom), 3'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))} ,
             $urandom, 5'($urandom_range(0, 31)));
      s.zero   = 1'($urandom_range(0, 1));
      s.target = $urandom;
      s.stall  = ($urandom_range(0, 99) < 15);
      s.flush  = ($urandom_range(0, 99) < 10);
      s.reset  = ($urandom_range(0, 99) < 2);
      apply(s);
    end
    apply(idle); apply(idle);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected states left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
